// File: rtl/core_if_fetch_q.sv
// Instruction fetch queue: records fetch PCs in order, pairs them with in-order
// L1I responses and hands complete instructions to decode; kills flush and drop stale responses.
module core_if_fetch_q #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_val,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_pc_4,
  output logic                     if_stop,
  input  logic                     l1i_ack,
  input  logic [31:0]              l1i_data,
  input  logic                     id_kill,
  output logic                     id_val,
  input  logic                     id_rdy,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_pc_4,
  output logic [$clog2(DEPTH):0]   id_cnt,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW+1:0] FULL_LVL = (AW+2)'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } ent_state_e;

  ent_state_e    st_q    [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   pc4_q   [DEPTH];
  logic [31:0]   instr_q [DEPTH];

  logic [AW-1:0] wr_ptr, rsp_ptr, rd_ptr;
  logic [AW:0]   drop_cnt, cnt_q;

  logic          alloc, pop, ack_drop, ack_fill, ack_spur, ack_used;
  logic [AW:0]   nwait;
  logic [AW+1:0] occ;

  // Outstanding requests (live entries plus responses owed to killed ones) bound the stop.
  assign occ     = {1'b0, cnt_q} + {1'b0, drop_cnt};
  assign if_stop = (occ >= FULL_LVL);

  assign id_val   = (st_q[rd_ptr] == READY);
  assign id_instr = instr_q[rd_ptr];
  assign id_pc    = pc_q[rd_ptr];
  assign id_pc_4  = pc4_q[rd_ptr];
  assign id_cnt   = cnt_q;

  assign alloc    = if_val & ~if_stop & ~id_kill;
  assign pop      = id_val & id_rdy & ~id_kill;
  assign ack_drop = l1i_ack & (drop_cnt != '0);
  assign ack_fill = l1i_ack & (drop_cnt == '0) & (st_q[rsp_ptr] == WAIT);
  assign ack_spur = l1i_ack & (drop_cnt == '0) & (st_q[rsp_ptr] != WAIT);
  assign ack_used = l1i_ack & ~ack_spur;

  always_comb begin
    nwait = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] == WAIT) nwait = nwait + CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every update reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the entry array is reset because its defined reset state is EMPTY with zero data.
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]    <= EMPTY;
        pc_q[i]    <= '0;
        pc4_q[i]   <= '0;
        instr_q[i] <= '0;
      end
      wr_ptr   <= '0;
      rsp_ptr  <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
      cnt_q    <= '0;
      err      <= 1'b0;
    end else begin
      if (ack_spur || (if_val && if_stop)) err <= 1'b1;

      if (id_kill) begin
        for (int i = 0; i < DEPTH; i++) st_q[i] <= EMPTY;
        wr_ptr   <= '0;
        rsp_ptr  <= '0;
        rd_ptr   <= '0;
        cnt_q    <= '0;
        // Every WAIT entry now owes a response to drop, minus one arriving this cycle.
        drop_cnt <= drop_cnt + nwait - (ack_used ? CNT_ONE : '0);
      end else begin
        if (alloc) begin
          st_q[wr_ptr]  <= WAIT;
          pc_q[wr_ptr]  <= if_pc;
          pc4_q[wr_ptr] <= if_pc_4;
          wr_ptr        <= wr_ptr + PTR_ONE;
        end
        if (ack_drop) drop_cnt <= drop_cnt - CNT_ONE;
        if (ack_fill) begin
          st_q[rsp_ptr]    <= READY;
          instr_q[rsp_ptr] <= l1i_data;
          rsp_ptr          <= rsp_ptr + PTR_ONE;
        end
        if (pop) begin
          st_q[rd_ptr] <= EMPTY;
          rd_ptr       <= rd_ptr + PTR_ONE;
        end
        case ({alloc, pop})
          2'b10:   cnt_q <= cnt_q + CNT_ONE;
          2'b01:   cnt_q <= cnt_q - CNT_ONE;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_if_fetch_q.sv
// Scoreboard bench for core_if_fetch_q: directed request/ack sequences push expected
// decode transfers; a negedge monitor compares every accepted head entry in order.
module tb_core_if_fetch_q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_val = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_pc_4 = '0;
  logic        if_stop;
  logic        l1i_ack = 1'b0;
  logic [31:0] l1i_data = '0;
  logic        id_kill = 1'b0;
  logic        id_val;
  logic        id_rdy = 1'b0;
  logic [31:0] id_instr, id_pc, id_pc_4;
  logic [2:0]  id_cnt;
  logic        err;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pops   = 0;

  core_if_fetch_q #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .if_val(if_val), .if_pc(if_pc), .if_pc_4(if_pc_4),
    .if_stop(if_stop), .l1i_ack(l1i_ack), .l1i_data(l1i_data), .id_kill(id_kill),
    .id_val(id_val), .id_rdy(id_rdy), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_4(id_pc_4), .id_cnt(id_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pc_4  = pc + 32'd4;
    sb.push_back(e);
  endtask

  // One clock of stimulus; outputs are then examined 1 ns after the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic a,
                      input logic [31:0] d, input logic k);
    if_val   = v;
    if_pc    = pc;
    if_pc_4  = pc + 32'd4;
    l1i_ack  = a;
    l1i_data = d;
    id_kill  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && id_val && id_rdy && !id_kill) begin
      n_pops++;
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pop_pc", id_pc, e.pc);
        check("pop_pc_4", id_pc_4, e.pc_4);
        check("pop_instr", id_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle(2);
    rst = 1'b0;
    check("rst_id_val", 32'(id_val), 32'd0);
    check("rst_id_cnt", 32'(id_cnt), 32'd0);
    check("rst_if_stop", 32'(if_stop), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_instr", id_instr, 32'd0);

    // Streaming, 1-cycle L1I, decode always ready
    id_rdy = 1'b1;
    push(32'h200, 32'h00A0_0093);
    push(32'h204, 32'h0010_8113);
    push(32'h208, 32'h0021_0193);
    step(1'b1, 32'h200, 1'b0, '0, 1'b0);
    step(1'b1, 32'h204, 1'b1, 32'h00A0_0093, 1'b0);
    check("stream_id_val", 32'(id_val), 32'd1);
    step(1'b1, 32'h208, 1'b1, 32'h0010_8113, 1'b0);
    step(1'b0, '0, 1'b1, 32'h0021_0193, 1'b0);
    idle(2);
    check("stream_cnt_end", 32'(id_cnt), 32'd0);

    // Backpressure until full, then a single pop, then wrap through six entries
    id_rdy = 1'b0;
    push(32'h300, 32'h1111_0001);
    push(32'h304, 32'h1111_0002);
    push(32'h308, 32'h1111_0003);
    push(32'h30C, 32'h1111_0004);
    step(1'b1, 32'h300, 1'b0, '0, 1'b0);
    step(1'b1, 32'h304, 1'b1, 32'h1111_0001, 1'b0);
    step(1'b1, 32'h308, 1'b1, 32'h1111_0002, 1'b0);
    step(1'b1, 32'h30C, 1'b1, 32'h1111_0003, 1'b0);
    step(1'b0, '0, 1'b1, 32'h1111_0004, 1'b0);
    check("full_id_cnt", 32'(id_cnt), 32'd4);
    check("full_if_stop", 32'(if_stop), 32'd1);
    id_rdy = 1'b1;
    idle(1);
    id_rdy = 1'b0;
    check("after_pop_cnt", 32'(id_cnt), 32'd3);
    check("after_pop_stop", 32'(if_stop), 32'd0);
    id_rdy = 1'b1;
    push(32'h310, 32'h1111_0005);
    push(32'h314, 32'h1111_0006);
    step(1'b1, 32'h310, 1'b0, '0, 1'b0);
    step(1'b1, 32'h314, 1'b1, 32'h1111_0005, 1'b0);
    step(1'b0, '0, 1'b1, 32'h1111_0006, 1'b0);
    idle(3);
    check("wrap_cnt_end", 32'(id_cnt), 32'd0);

    // Kill with two requests still in flight: their responses must be discarded
    id_rdy = 1'b0;
    step(1'b1, 32'h500, 1'b0, '0, 1'b0);
    step(1'b1, 32'h504, 1'b1, 32'hDEAD_0000, 1'b0);
    step(1'b1, 32'h508, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    check("kill_id_val", 32'(id_val), 32'd0);
    check("kill_id_cnt", 32'(id_cnt), 32'd0);
    push(32'h400, 32'h0000_0013);
    push(32'h404, 32'h0000_0017);
    step(1'b1, 32'h400, 1'b0, '0, 1'b0);
    step(1'b1, 32'h404, 1'b0, '0, 1'b0);
    check("kill_owed_cnt", 32'(id_cnt), 32'd2);
    check("kill_owed_stop", 32'(if_stop), 32'd1);
    id_rdy = 1'b1;
    step(1'b0, '0, 1'b1, 32'hDEAD_0001, 1'b0);
    step(1'b0, '0, 1'b1, 32'hDEAD_0002, 1'b0);
    check("kill_drop_no_val", 32'(id_val), 32'd0);
    step(1'b0, '0, 1'b1, 32'h0000_0013, 1'b0);
    step(1'b0, '0, 1'b1, 32'h0000_0017, 1'b0);
    idle(2);
    check("kill_err", 32'(err), 32'd0);
    check("kill_cnt_end", 32'(id_cnt), 32'd0);

    // Kill coincident with an ack and an if_val: one response remains owed
    step(1'b1, 32'h700, 1'b0, '0, 1'b0);
    step(1'b1, 32'h704, 1'b0, '0, 1'b0);
    step(1'b1, 32'h708, 1'b1, 32'hDEAD_0003, 1'b1);
    check("coin_id_cnt", 32'(id_cnt), 32'd0);
    check("coin_id_val", 32'(id_val), 32'd0);
    step(1'b0, '0, 1'b1, 32'hDEAD_0004, 1'b0);
    push(32'h800, 32'h0000_0033);
    step(1'b1, 32'h800, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 32'h0000_0033, 1'b0);
    idle(2);
    check("coin_err", 32'(err), 32'd0);

    // Spurious ack on an empty queue is sticky until reset
    step(1'b0, '0, 1'b1, 32'hBAD0_0000, 1'b0);
    check("spur_err", 32'(err), 32'd1);
    check("spur_cnt", 32'(id_cnt), 32'd0);
    check("spur_val", 32'(id_val), 32'd0);
    idle(3);
    check("spur_sticky", 32'(err), 32'd1);
    do_reset();
    check("spur_cleared", 32'(err), 32'd0);

    // if_val while stopped is ignored and flagged
    id_rdy = 1'b0;
    step(1'b1, 32'h900, 1'b0, '0, 1'b0);
    step(1'b1, 32'h904, 1'b0, '0, 1'b0);
    step(1'b1, 32'h908, 1'b0, '0, 1'b0);
    step(1'b1, 32'h90C, 1'b0, '0, 1'b0);
    check("stop_set", 32'(if_stop), 32'd1);
    check("stop_err_clear", 32'(err), 32'd0);
    step(1'b1, 32'h9F0, 1'b0, '0, 1'b0);
    check("stop_req_err", 32'(err), 32'd1);
    check("stop_req_cnt", 32'(id_cnt), 32'd4);
    do_reset();

    // Reset mid-stream with three READY entries
    step(1'b1, 32'hA00, 1'b0, '0, 1'b0);
    step(1'b1, 32'hA04, 1'b1, 32'h2222_0001, 1'b0);
    step(1'b1, 32'hA08, 1'b1, 32'h2222_0002, 1'b0);
    step(1'b0, '0, 1'b1, 32'h2222_0003, 1'b0);
    check("mid_cnt", 32'(id_cnt), 32'd3);
    check("mid_head_pc", id_pc, 32'hA00);
    check("mid_head_instr", id_instr, 32'h2222_0001);
    rst = 1'b1;
    idle(1);
    check("mid_rst_val", 32'(id_val), 32'd0);
    check("mid_rst_cnt", 32'(id_cnt), 32'd0);
    check("mid_rst_stop", 32'(if_stop), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_pc", id_pc, 32'd0);
    check("mid_rst_pc_4", id_pc_4, 32'd0);
    check("mid_rst_instr", id_instr, 32'd0);
    rst = 1'b0;
    idle(1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("total_pops", 32'(n_pops), 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_if_fetch_q.md
# core_if_fetch_q

Instruction fetch queue between the fetch stage and decode. Fetch issues a request to the L1 instruction cache with `if_val` and `if_pc`. This block then:
- records each request's PC in order;
- pairs it with the in-order `l1i_ack`/`l1i_data` response;
- presents complete instructions to decode through a valid/ready handshake.

It drives `if_stop` back to fetch as backpressure. On a redirect kill it flushes all entries and discards responses that are still in flight.

## Interface
Parameters:
- `DEPTH`, default 4: number of queue entries; must be a power of 2 and ≥ 2.

Ports:
- `clk`, in, 1: system clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `if_val`, in, 1: fetch issued an L1I request this cycle.
- `if_pc`, in, 32: PC of the issued request.
- `if_pc_4`, in, 32: PC+4 of the issued request.
- `if_stop`, out, 1: queue cannot take a new request; fetch holds its PC.
- `l1i_ack`, in, 1: L1I response valid; responses arrive in request order.
- `l1i_data`, in, 32: instruction word of the response.
- `id_kill`, in, 1: redirect (branch/jump/hazard flush).
- `id_val`, out, 1: head entry holds a complete instruction.
- `id_rdy`, in, 1: decode accepts the head entry.
- `id_instr`, out, 32: head instruction.
- `id_pc`, out, 32: head PC.
- `id_pc_4`, out, 32: head PC+4.
- `id_cnt`, out, log2(DEPTH)+1: number of allocated entries.
- `err`, out, 1: sticky protocol error flag.

## Operation
- Storage is a ring of `DEPTH` entries. Each entry holds `{state, pc, pc_4, instr}`, where state is EMPTY, WAIT or READY.
- Three pointers, each log2(DEPTH) bits and wrapping modulo `DEPTH`:
  - `wr_ptr` (allocate);
  - `rsp_ptr` (fill);
  - `rd_ptr` (pop).
- `drop_cnt` (log2(DEPTH)+1 bits) counts responses still owed for killed requests.
- **Allocate:** `if_val & ~if_stop & ~id_kill` writes `{WAIT, if_pc, if_pc_4}` at `wr_ptr`, then `wr_ptr++`.
- **Response:** `l1i_ack` with `drop_cnt != 0` decrements `drop_cnt` and discards the data.
- Otherwise, `l1i_ack` with entry[`rsp_ptr`] == WAIT stores `l1i_data`, sets READY, then `rsp_ptr++`.
- **Spurious response:** `l1i_ack` with no WAIT entry and `drop_cnt == 0` is ignored and sets `err`. `err` is cleared only by `rst`.
- **Pop:** `id_val & id_rdy` sets entry[`rd_ptr`] to EMPTY, then `rd_ptr++`.
- `id_val` = (entry[`rd_ptr`] == READY).
- `id_instr`, `id_pc` and `id_pc_4` are muxed from entry[`rd_ptr`]. They are purely register-sourced, with no combinational path from `l1i_ack`.
- `if_stop` = (`id_cnt + drop_cnt >= DEPTH`), computed from registered state only. This bounds outstanding L1I requests to `DEPTH`.
- If fetch asserts `if_val` while `if_stop` is high, the request is ignored and `err` is set.
- **Kill:** `id_kill` has priority over all other events in the same cycle:
  - all entries go to EMPTY and all pointers go to 0;
  - `drop_cnt` ← `drop_cnt` + (#WAIT entries) − (`l1i_ack` ? 1 : 0);
  - a same-cycle `if_val` is ignored;
  - a same-cycle pop does not happen (`id_val` is still shown, but decode is being killed too).
- Allocate, response and pop may all occur in one cycle. Each acts on a distinct entry, and `id_cnt` changes by (alloc − pop).

## Timing
- Reset values:
  - all entries EMPTY with data 0;
  - pointers 0, `drop_cnt` 0, `err` 0;
  - `id_val` 0, `id_instr`/`id_pc`/`id_pc_4` = 0;
  - `if_stop` 0, `id_cnt` 0.
- `rst` asserted mid-operation clears everything in that cycle; any L1I responses still in flight afterwards are the system's responsibility (not counted).
- Latency:
  - `l1i_ack` at cycle N → `id_val` high at N+1 when the entry is at the head;
  - pop at cycle N → next head visible at N+1.
- Throughput: one alloc, one fill and one pop per cycle. With a 1-cycle L1I the queue sustains 1 instruction/cycle.
- Full: `id_cnt == DEPTH` → `if_stop` = 1. A pop in that cycle does not permit a same-cycle allocate; `if_stop` falls the next cycle.
- Empty: `id_val` = 0 and the outputs show entry[`rd_ptr`] contents (stale data is permitted).
- Wrap-around: pointers roll from `DEPTH`−1 to 0 with no bubble.

## Test plan
- **Streaming:** reset, `DEPTH`=4, then `if_val` with pc 0x200, 0x204, 0x208 on consecutive cycles, acks one cycle later each, `id_rdy`=1. Expect `id_val` on 3 consecutive cycles with `id_pc` 0x200/0x204/0x208, `id_pc_4` 0x204/0x208/0x20C, `id_instr` equal to the acked data.
- **Backpressure/full:** `id_rdy`=0, 4 requests all acked. Expect `id_cnt`=4 and `if_stop`=1. Then `id_rdy`=1 for 1 cycle: `id_cnt`=3 and `if_stop`=0 the next cycle. Ordering is preserved across a 6-entry wrap.
- **Kill with in-flight requests:** 3 requests, 1 acked, then `id_kill`. Expect `id_val`=0 and `drop_cnt`=2. The next 2 acks are discarded. A new request at 0x400 is acked with 0x13, giving `id_pc`=0x400 and `id_instr`=0x13.
- **Kill coincident with ack and if_val:** 2 WAIT entries; `id_kill`, `l1i_ack` and `if_val` in the same cycle. Expect `drop_cnt`=1, no allocation and `id_cnt`=0.
- **Protocol errors:** `l1i_ack` with an empty queue → `err`=1, queue unchanged. `err` stays set until `rst`. Separately, `if_val` while `if_stop`=1 → ignored and `err`=1.
- **Reset mid-stream:** assert `rst` with 3 READY entries. All outputs go to their reset values the next cycle.
